// File: rtl/rom_stream_reader_pkg.sv
// rtl/rom_stream_reader_pkg.sv - shared types and constants for the ROM stream reader
package rom_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Output buffer depth; the issue credit is sized against this.
  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/rom_stream_reader_if.sv
// rtl/rom_stream_reader_if.sv - command, memory and output stream bundle of the reader
interface rom_stream_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  start_valid;
  logic                  start_ready;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [LEN_WIDTH-1:0]  start_len;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;

  // Reader side: consumes commands and memory data, produces the stream.
  modport master (
    input  start_valid, start_addr, start_len, mem_data, out_ready,
    output start_ready, mem_addr, out_valid, out_data, out_last, busy
  );

  // Environment side: command source, memory and stream consumer.
  modport slave (
    output start_valid, start_addr, start_len, mem_data, out_ready,
    input  start_ready, mem_addr, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/rom_stream_reader_fifo.sv
// rtl/rom_stream_reader_fifo.sv - 2-entry output buffer holding {last,data}
module stream_fifo2
  import rom_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  push_last_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [1:0]            count_o,
  output logic                  valid_o,
  output logic                  last_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic [DATA_WIDTH:0] slot_q [FIFO_DEPTH];
  logic                rd_ptr_q;
  logic                wr_ptr_q;
  logic [1:0]          count_q;

  // Storage, pointers and occupancy; push and pop may happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) slot_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        slot_q[wr_ptr_q] <= {push_last_i, push_data_i};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign count_o          = count_q;
  assign valid_o          = (count_q != 2'd0);
  assign {last_o, data_o} = slot_q[rd_ptr_q];

endmodule

// File: rtl/rom_stream_reader.sv
// rtl/rom_stream_reader.sv - sequential reader from a registered-address memory onto a valid/ready stream
module rom_stream_reader
  import rom_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                clk,
  input  logic                rst,
  rom_stream_reader_if.master bus
);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  inflight_q, inflight_last_q;
  logic                  issue, last_issue, credit_ok, pop;
  logic [1:0]            fifo_count;
  logic [2:0]            occupancy;
  logic                  fifo_valid, fifo_last;
  logic [DATA_WIDTH-1:0] fifo_data;

  // Words buffered or on their way from memory; pop frees a slot this cycle.
  assign pop       = fifo_valid & bus.out_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign credit_ok = (occupancy - {2'b00, pop}) < 3'd2;

  // Next-state, counter updates and address issue decision.
  always_comb begin
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    remaining_d = remaining_q;
    issue       = 1'b0;
    last_issue  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_valid && bus.start_len != '0) begin
          addr_cnt_d  = bus.start_addr;
          remaining_d = bus.start_len;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (remaining_q != '0 && credit_ok) begin
          issue       = 1'b1;
          addr_cnt_d  = addr_cnt_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_WIDTH'(1)) begin
            last_issue = 1'b1;
            state_d    = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && fifo_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The memory has no enable, so the address simply holds between issues.
  assign last_addr_d = issue ? addr_cnt_q : last_addr_q;

  // State, counters and the one-deep in-flight tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_cnt_q      <= '0;
      last_addr_q     <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_cnt_q      <= addr_cnt_d;
      last_addr_q     <= last_addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
    end
  end

  stream_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_last_i (inflight_last_q),
    .push_data_i (bus.mem_data),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .valid_o     (fifo_valid),
    .last_o      (fifo_last),
    .data_o      (fifo_data)
  );

  assign bus.mem_addr    = last_addr_d;
  assign bus.start_ready = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.out_valid   = fifo_valid;
  assign bus.out_data    = fifo_data;
  assign bus.out_last    = fifo_last;

endmodule
